// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and elaboration helpers for the burst memory slave.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        while ((32'sd1 << result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational AXI4 next-beat address calculator with a burst legality flag.
module axi_addr_gen
    import axi_pkg::*;
#(
    parameter int DATA_W = 32'sd32,
    parameter int ADDR_W = 32'sd12
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              legal
);

    localparam logic [2:0]        MAX_SIZE = 3'(clog2(DATA_W / 8));
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1'b1);
    localparam logic [ADDR_W-1:0] ZERO     = {ADDR_W{1'b0}};

    logic [ADDR_W-1:0] bytes_s;
    logic [ADDR_W-1:0] aligned_s;
    logic [ADDR_W-1:0] incr_s;
    logic [ADDR_W-1:0] window_s;
    logic [ADDR_W-1:0] wrap_mask_s;
    logic              wrap_len_ok_s;

    // Beat size, aligned increment and wrap window
    always_comb begin
        bytes_s       = ONE << size;
        aligned_s     = addr & ~(bytes_s - ONE);
        incr_s        = aligned_s + bytes_s;
        window_s      = bytes_s * (ADDR_W'(len) + ONE);
        wrap_mask_s   = window_s - ONE;
        wrap_len_ok_s = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    end

    // Legality of the burst as described by the current fields
    always_comb begin
        legal = 1'b1;
        if (size > MAX_SIZE) begin
            legal = 1'b0;
        end else if (burst == BURST_RSVD) begin
            legal = 1'b0;
        end else if ((burst == BURST_WRAP) &&
                     (!wrap_len_ok_s || ((addr & (bytes_s - ONE)) != ZERO))) begin
            legal = 1'b0;
        end else begin
            legal = 1'b1;
        end
    end

    // Next-beat address selection per burst type
    always_comb begin
        next_addr = addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incr_s;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask_s) | (incr_s & wrap_mask_s);
            default:     next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst RAM target: independent write and read FSMs over one 1W/1R array.
module axi_burst_mem_slave
    import axi_pkg::*;
#(
    parameter int DATA_W = 32'sd32,
    parameter int ADDR_W = 32'sd12,
    parameter int DEPTH  = 32'sd256,
    parameter int ID_W   = 32'sd4
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF    = clog2(STRB_W);
    localparam int IDX_W  = clog2(DEPTH);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // Addresses above DEPTH alias onto the array by dropping the high bits.
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return a[OFF +: IDX_W];
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [1:0]        w_state_r;
    logic [ID_W-1:0]   w_id_r;
    logic [ADDR_W-1:0] w_addr_r;
    logic [7:0]        w_len_r;
    logic [2:0]        w_size_r;
    logic [1:0]        w_burst_r;
    logic [7:0]        w_cnt_r;
    logic              w_err_r;
    logic              w_proto_r;

    logic [0:0]        r_state_r;
    logic [ADDR_W-1:0] r_addr_r;
    logic [7:0]        r_len_r;
    logic [2:0]        r_size_r;
    logic [1:0]        r_burst_r;
    logic [7:0]        r_cnt_r;
    logic              r_err_r;

    logic [ADDR_W-1:0] aw_addr_s, aw_next_s, ar_addr_s, ar_next_s;
    logic [7:0]        aw_len_s, ar_len_s;
    logic [2:0]        aw_size_s, ar_size_s;
    logic [1:0]        aw_burst_s, ar_burst_s;
    logic              aw_legal_s, ar_legal_s;
    logic              w_hs_s, w_final_s, w_proto_s;

    // Address generators see the incoming request while idle, the latched burst otherwise
    always_comb begin
        if (w_state_r == W_IDLE) begin
            aw_addr_s  = awaddr;
            aw_len_s   = awlen;
            aw_size_s  = awsize;
            aw_burst_s = awburst;
        end else begin
            aw_addr_s  = w_addr_r;
            aw_len_s   = w_len_r;
            aw_size_s  = w_size_r;
            aw_burst_s = w_burst_r;
        end
        if (r_state_r == R_IDLE) begin
            ar_addr_s  = araddr;
            ar_len_s   = arlen;
            ar_size_s  = arsize;
            ar_burst_s = arburst;
        end else begin
            ar_addr_s  = r_addr_r;
            ar_len_s   = r_len_r;
            ar_size_s  = r_size_r;
            ar_burst_s = r_burst_r;
        end
    end

    axi_addr_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_aw_gen (
        .addr(aw_addr_s), .size(aw_size_s), .len(aw_len_s), .burst(aw_burst_s),
        .next_addr(aw_next_s), .legal(aw_legal_s)
    );

    axi_addr_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ar_gen (
        .addr(ar_addr_s), .size(ar_size_s), .len(ar_len_s), .burst(ar_burst_s),
        .next_addr(ar_next_s), .legal(ar_legal_s)
    );

    // Write beat qualification; burst length follows awlen, wlast only flags errors
    always_comb begin
        w_hs_s    = (w_state_r == W_DATA) && wvalid && wready;
        w_final_s = (w_cnt_r == w_len_r);
        w_proto_s = (wlast != w_final_s);
    end

    // Write FSM and B channel
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_r <= W_IDLE;
            awready   <= 1'b1;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bid       <= {ID_W{1'b0}};
            bresp     <= RESP_OKAY;
            w_id_r    <= {ID_W{1'b0}};
            w_addr_r  <= {ADDR_W{1'b0}};
            w_len_r   <= 8'd0;
            w_size_r  <= 3'd0;
            w_burst_r <= BURST_FIXED;
            w_cnt_r   <= 8'd0;
            w_err_r   <= 1'b0;
            w_proto_r <= 1'b0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        w_id_r    <= awid;
                        w_addr_r  <= awaddr;
                        w_len_r   <= awlen;
                        w_size_r  <= awsize;
                        w_burst_r <= awburst;
                        w_err_r   <= !aw_legal_s;
                        w_cnt_r   <= 8'd0;
                        w_proto_r <= 1'b0;
                        awready   <= 1'b0;
                        wready    <= 1'b1;
                        w_state_r <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs_s) begin
                        w_addr_r <= aw_next_s;
                        w_cnt_r  <= w_cnt_r + 8'd1;
                        if (w_final_s) begin
                            wready    <= 1'b0;
                            bvalid    <= 1'b1;
                            bid       <= w_id_r;
                            bresp     <= (w_err_r || w_proto_r || w_proto_s) ? RESP_SLVERR : RESP_OKAY;
                            w_state_r <= W_RESP;
                        end else begin
                            w_proto_r <= w_proto_r | w_proto_s;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid && bready) begin
                        bvalid    <= 1'b0;
                        awready   <= 1'b1;
                        w_state_r <= W_IDLE;
                    end
                end
                default: begin
                    w_state_r <= W_IDLE;
                    awready   <= 1'b1;
                    wready    <= 1'b0;
                    bvalid    <= 1'b0;
                end
            endcase
        end
    end

    // Byte-strobed memory write port; erroneous bursts never touch the array
    always_ff @(posedge aclk) begin
        if (!areset && w_hs_s && !w_err_r) begin
            for (int b = 32'sd0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem_r[word_idx(w_addr_r)][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read FSM with registered memory read; a same-cycle write is seen as old data
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_r <= R_IDLE;
            arready   <= 1'b1;
            rvalid    <= 1'b0;
            rdata     <= {DATA_W{1'b0}};
            rresp     <= RESP_OKAY;
            rlast     <= 1'b0;
            rid       <= {ID_W{1'b0}};
            r_addr_r  <= {ADDR_W{1'b0}};
            r_len_r   <= 8'd0;
            r_size_r  <= 3'd0;
            r_burst_r <= BURST_FIXED;
            r_cnt_r   <= 8'd0;
            r_err_r   <= 1'b0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        r_addr_r  <= ar_next_s;
                        r_len_r   <= arlen;
                        r_size_r  <= arsize;
                        r_burst_r <= arburst;
                        r_err_r   <= !ar_legal_s;
                        r_cnt_r   <= 8'd0;
                        rid       <= arid;
                        rvalid    <= 1'b1;
                        rlast     <= (arlen == 8'd0);
                        rresp     <= ar_legal_s ? RESP_OKAY : RESP_SLVERR;
                        rdata     <= ar_legal_s ? mem_r[word_idx(araddr)] : {DATA_W{1'b0}};
                        arready   <= 1'b0;
                        r_state_r <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid && rready) begin
                        if (rlast) begin
                            rvalid    <= 1'b0;
                            rlast     <= 1'b0;
                            arready   <= 1'b1;
                            r_state_r <= R_IDLE;
                        end else begin
                            r_addr_r <= ar_next_s;
                            r_cnt_r  <= r_cnt_r + 8'd1;
                            rlast    <= ((r_cnt_r + 8'd1) == r_len_r);
                            rdata    <= r_err_r ? {DATA_W{1'b0}} : mem_r[word_idx(r_addr_r)];
                        end
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                    arready   <= 1'b1;
                    rvalid    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Directed self-checking bench for axi_burst_mem_slave.
module tb_axi_burst_mem_slave;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;
    localparam int         BOUND = 50;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  awid, arid, bid, rid;
    logic [11:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 aclk = ~aclk;

    axi_burst_mem_slave dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (awready !== 1'b1 && n < BOUND) begin step(); n++; end
        check("aw_ready", 32'(awready), 32'd1);
        step();
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        while (wready !== 1'b1 && n < BOUND) begin step(); n++; end
        check("w_ready", 32'(wready), 32'd1);
        step();
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic do_b(input string tag, input logic [3:0] exp_id, input logic [1:0] exp_resp);
        int n = 0;
        bready = 1'b1;
        while (bvalid !== 1'b1 && n < BOUND) begin step(); n++; end
        check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
        check({tag, "_bid"}, 32'(bid), 32'(exp_id));
        check({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
        step();
        bready = 1'b0;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        while (arready !== 1'b1 && n < BOUND) begin step(); n++; end
        check("ar_ready", 32'(arready), 32'd1);
        step();
        arvalid = 1'b0;
        check("r_first_latency", 32'(rvalid), 32'd1);
    endtask

    task automatic do_r(input string tag, input logic [31:0] exp_data, input logic exp_last,
                        input logic [1:0] exp_resp);
        int n = 0;
        rready = 1'b1;
        while (rvalid !== 1'b1 && n < BOUND) begin step(); n++; end
        check({tag, "_rdata"}, rdata, exp_data);
        check({tag, "_rlast"}, 32'(rlast), 32'(exp_last));
        check({tag, "_rresp"}, 32'(rresp), 32'(exp_resp));
        step();
        rready = 1'b0;
    endtask

    initial begin
        areset = 1'b1;
        awid = 4'd0; awaddr = 12'h0; awlen = 8'd0; awsize = 3'd0; awburst = FIXED; awvalid = 1'b0;
        wdata = 32'h0; wstrb = 4'h0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = 4'd0; araddr = 12'h0; arlen = 8'd0; arsize = 3'd0; arburst = FIXED; arvalid = 1'b0;
        rready = 1'b0;
        step();
        step();
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        areset = 1'b0;
        step();

        // INCR write then INCR readback of the same four words
        do_aw(4'd3, 12'h000, 8'd3, 3'd2, INCR);
        do_w(32'h11, 4'hF, 1'b0);
        do_w(32'h22, 4'hF, 1'b0);
        do_w(32'h33, 4'hF, 1'b0);
        do_w(32'h44, 4'hF, 1'b1);
        do_b("incr_wr", 4'd3, 2'b00);
        do_ar(4'd5, 12'h000, 8'd3, 3'd2, INCR);
        check("incr_rid", 32'(rid), 32'd5);
        do_r("incr_b0", 32'h11, 1'b0, 2'b00);
        do_r("incr_b1", 32'h22, 1'b0, 2'b00);
        do_r("incr_b2", 32'h33, 1'b0, 2'b00);
        do_r("incr_b3", 32'h44, 1'b1, 2'b00);
        check("incr_done_rvalid", 32'(rvalid), 32'd0);

        // Strobed write over a zeroed word
        do_aw(4'd1, 12'h010, 8'd0, 3'd2, INCR);
        do_w(32'h0, 4'hF, 1'b1);
        do_b("zero_wr", 4'd1, 2'b00);
        do_aw(4'd2, 12'h010, 8'd0, 3'd2, INCR);
        do_w(32'hAABBCCDD, 4'b0101, 1'b1);
        do_b("strb_wr", 4'd2, 2'b00);
        do_ar(4'd6, 12'h010, 8'd0, 3'd2, INCR);
        do_r("strb_rd", 32'h00BB00DD, 1'b1, 2'b00);

        // WRAP read from word 2: words 2,3,0,1
        do_ar(4'd7, 12'h008, 8'd3, 3'd2, WRAP);
        do_r("wrap_b0", 32'h33, 1'b0, 2'b00);
        do_r("wrap_b1", 32'h44, 1'b0, 2'b00);
        do_r("wrap_b2", 32'h11, 1'b0, 2'b00);
        do_r("wrap_b3", 32'h22, 1'b1, 2'b00);

        // WRAP with three beats is illegal: SLVERR and memory untouched
        do_aw(4'd4, 12'h000, 8'd2, 3'd2, WRAP);
        do_w(32'hDEAD0001, 4'hF, 1'b0);
        do_w(32'hDEAD0002, 4'hF, 1'b0);
        do_w(32'hDEAD0003, 4'hF, 1'b1);
        do_b("wrap_err", 4'd4, 2'b10);
        do_ar(4'd8, 12'h000, 8'd2, 3'd2, INCR);
        do_r("keep_b0", 32'h11, 1'b0, 2'b00);
        do_r("keep_b1", 32'h22, 1'b0, 2'b00);
        do_r("keep_b2", 32'h33, 1'b1, 2'b00);

        // rready pattern 1,0,0,1: data held while stalled, no beat lost
        do_ar(4'd9, 12'h000, 8'd3, 3'd2, INCR);
        rready = 1'b1;
        check("stall_b0", rdata, 32'h11);
        step();
        rready = 1'b0;
        check("stall_b1", rdata, 32'h22);
        step();
        check("stall_hold1", rdata, 32'h22);
        check("stall_hold1_valid", 32'(rvalid), 32'd1);
        step();
        check("stall_hold2", rdata, 32'h22);
        rready = 1'b1;
        step();
        check("stall_b2", rdata, 32'h33);
        check("stall_b2_last", 32'(rlast), 32'd0);
        step();
        check("stall_b3", rdata, 32'h44);
        check("stall_b3_last", 32'(rlast), 32'd1);
        step();
        rready = 1'b0;
        check("stall_end_rvalid", 32'(rvalid), 32'd0);

        // Reset after two beats of a four-beat write
        do_aw(4'd1, 12'h020, 8'd3, 3'd2, INCR);
        do_w(32'hA1, 4'hF, 1'b0);
        do_w(32'hA2, 4'hF, 1'b0);
        areset = 1'b1;
        step();
        areset = 1'b0;
        check("mid_rst_bvalid", 32'(bvalid), 32'd0);
        check("mid_rst_awready", 32'(awready), 32'd1);
        check("mid_rst_wready", 32'(wready), 32'd0);
        do_aw(4'd2, 12'h020, 8'd0, 3'd2, INCR);
        do_w(32'h55AA, 4'hF, 1'b1);
        do_b("post_rst", 4'd2, 2'b00);
        do_ar(4'd6, 12'h020, 8'd0, 3'd2, INCR);
        do_r("post_rst_rd", 32'h55AA, 1'b1, 2'b00);

        // Early wlast on beat 2: all four beats still taken, SLVERR
        do_aw(4'd7, 12'h030, 8'd3, 3'd2, INCR);
        do_w(32'h1, 4'hF, 1'b0);
        do_w(32'h2, 4'hF, 1'b1);
        do_w(32'h3, 4'hF, 1'b0);
        check("early_wlast_wready", 32'(wready), 32'd1);
        check("early_wlast_bvalid", 32'(bvalid), 32'd0);
        do_w(32'h4, 4'hF, 1'b1);
        do_b("early_wlast", 4'd7, 2'b10);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/axi_burst_mem_slave.md
Name: axi_burst_mem_slave

Overview:
- AXI4 memory slave; successor of the single-beat write-only slave.
- Adds a parametrised data width, memory depth and ID width.
- Supports FIXED, INCR and WRAP bursts of up to 256 beats, byte strobes, and a full read path.
- Independent write and read FSMs share one memory array: one write port, one read port. Sits behind the interconnect as a generic RAM target.

Parameters:
- DATA_W, 32, data bus width; a multiple of 8, from 32 to 128.
- ADDR_W, 12, byte address width.
- DEPTH, 256, memory words; power of 2; DEPTH*DATA_W/8 <= 2^ADDR_W.
- ID_W, 4, transaction ID width.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- awid  in  ID_W  write ID.
- awaddr  in  ADDR_W  write byte address.
- awlen  in  8  beats-1.
- awsize  in  3  log2 bytes per beat.
- awburst  in  2  00 FIXED, 01 INCR, 10 WRAP.
- awvalid  in  1 / awready  out  1  write address handshake.
- wdata  in  DATA_W / wstrb  in  DATA_W/8 / wlast  in  1.
- wvalid  in  1 / wready  out  1  write data handshake.
- bid  out  ID_W / bresp  out  2.
- bvalid  out  1 / bready  in  1  write response handshake.
- arid, araddr, arlen, arsize, arburst: in; same widths as the AW fields.
- arvalid  in  1 / arready  out  1  read address handshake.
- rid  out  ID_W / rdata  out  DATA_W / rresp  out  2 / rlast  out  1.
- rvalid  out  1 / rready  in  1  read data handshake.

Behaviour:
- Reset (areset=1 at posedge): both FSMs go to IDLE.
- All outputs reset to 0, except awready=1 and arready=1.
- Memory contents are not reset.
- A handshake is valid & ready sampled at a posedge.

- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1, wready=0. On AW handshake, latch id, addr, len, size and burst, compute the error flag, go to W_DATA.
  - W_DATA: awready=0, wready=1. Each W handshake writes the bytes enabled by wstrb at the current word index, then advances the address.
  - Transition to W_RESP on the beat where the beat counter equals awlen, whether or not wlast is set.
  - wlast asserted early, or missing on the final beat, sets bresp=SLVERR (10). The burst length is still governed by awlen.
  - W_RESP: bvalid=1, bid=latched id. bvalid holds until bready, then goes to W_IDLE; awready=1 on the next cycle.
  - W data arriving before AW is not accepted (wready=0 in W_IDLE).

- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On AR handshake, latch the fields; arready=0 from the next cycle.
  - The first rvalid comes 1 cycle after the AR handshake (registered memory read).
  - R_DATA: rdata, rresp, rlast and rid are held stable while rvalid=1 and rready=0.
  - On an R handshake, the next beat is presented on the following cycle.
  - rvalid stays high across back-to-back beats, so rready held high gives 1 beat per cycle after the first.
  - rlast=1 only on beat arlen. The handshake of that beat returns to R_IDLE.

- Address generation (shared by both channels):
  - bytes = 1<<size. Word index = addr[ADDR_W-1 : log2(DATA_W/8)] modulo DEPTH.
  - FIXED: the address is constant.
  - INCR: addr += bytes. The first beat of an unaligned INCR advances to the next aligned boundary.
  - WRAP: len+1 must be 2, 4, 8 or 16. Window = bytes*(len+1), aligned down. The address wraps to the window base when the window top is crossed.

- Errors, response SLVERR (10):
  - size > log2(DATA_W/8);
  - burst=11 (reserved);
  - WRAP with an illegal length;
  - WRAP with an unaligned start address.
- Error handling:
  - Write: on a latched error, beats are accepted but no memory writes occur; bresp=10.
  - Read: on a latched error, all beats return rdata=0, rresp=10, and the correct beat count is kept.
  - Otherwise OKAY (00).
  - Addresses beyond DEPTH wrap (aliasing); this is not an error.

- Simultaneous read and write to the same word in the same cycle: the read returns the old data.
- Read and write channels run fully concurrently.
- Reset mid-burst: both FSMs abort immediately; no further beats and no B response. The master must also be reset.

Decomposition:
- Package axi_pkg:
  - burst encodings BURST_FIXED, BURST_INCR, BURST_WRAP;
  - response encodings RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR;
  - function clog2.
- Sub-module axi_addr_gen: combinational next-address calculator from (addr, size, len, burst), plus a legality flag.
- Instantiated twice, once for AW and once for AR.

Test Plan:
- INCR write: awaddr=0x000, awlen=3, awsize=2, wdata 0x11..0x44, wstrb=F. Then INCR read of the same span -> rdata 0x11, 0x22, 0x33, 0x44; rlast on beat 4 only; bresp=00; bid and rid echo the IDs.
- Strobe write: 0xAABBCCDD with wstrb=0101 over 0x00000000 -> readback 0x00BB00DD.
- WRAP read: araddr=0x008, arlen=3, arsize=2 -> word sequence 2, 3, 0, 1.
- WRAP with awlen=2 -> bresp=10 and memory unchanged.
- rready toggles 1,0,0,1 during a 4-beat read -> rdata stable while stalled; no beat lost or duplicated.
- areset=1 mid write burst after beat 2 -> bvalid=0, awready=1 one cycle after reset; the next transaction completes normally.
- wlast on beat 2 of awlen=3 -> 4 beats accepted, bresp=10.
